ex_div: RTL and testbench

- Iterative radix-2 restoring divider used by the EX stage for DIV/DIVU.
- Sits directly downstream of the ID/EX pipeline register, beside the ALU. Operands come from the ex_rf_rdata1 and ex_rf_rdata2 values after forwarding.
- Returns {remainder, quotient} for the HI/LO write path.
- Raises a stall request so the pipeline holds the instruction in EX until the result is ready.

---
 rtl/ex_div_pkg.sv | 20 ++
 rtl/ex_div_step.sv | 32 +++
 rtl/ex_div.sv | 158 +++++++++++++++
 tb/tb_ex_div.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ex_div_pkg.sv
// Shared definitions for the EX-stage divider: FSM state encodings and the
// ready/start level names used by the HI/LO write path and stall controller.
// No logic lives here; everything is constants and types.
package ex_div_pkg;

    // Divider FSM states (2-bit encoding)
    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;

endpackage

// File: rtl/ex_div_step.sv
// One radix-2 restoring shift-subtract iteration on the {rem, quo} pair.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
module ex_div_step
    import ex_div_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] quo,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic [DATA_W-1:0] quo_next
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] trial;

    // Shift the pair left one bit, trial-subtract, and restore if it went negative
    always_comb begin
        shifted = {rem, quo[DATA_W-1]};
        trial   = shifted - {1'b0, divisor};
        if (!trial[DATA_W]) begin
            rem_next = trial[DATA_W-1:0];
            quo_next = {quo[DATA_W-2:0], 1'b1};
        end else begin
            rem_next = shifted[DATA_W-1:0];
            quo_next = {quo[DATA_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_div.sv
// EX-stage DIV/DIVU iterative divider returning {remainder, quotient}; DIV_EARLY_OUT_EN enables |op1|<|op2| shortcut.
// Latency: ready at t+33 for a normal divide, t+2 for divide-by-zero, t+1 for an early-out.
// Backpressure: stallreq holds EX until ready; result is held in END while start stays high.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  start,
    input  logic                  signed_div,
    input  logic [DATA_W-1:0]     opdata1,
    input  logic [DATA_W-1:0]     opdata2,
    output logic [2*DATA_W-1:0]   result,
    output logic                  ready,
    output logic                  stallreq
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    div_state_t           state_q, state_n;
    logic [CNT_W-1:0]     cnt_q, cnt_n;
    logic [DATA_W-1:0]    rem_q, rem_n;
    logic [DATA_W-1:0]    quo_q, quo_n;
    logic [DATA_W-1:0]    dvsr_q, dvsr_n;
    logic                 neg_quo_q, neg_quo_n;
    logic                 neg_rem_q, neg_rem_n;
    logic [2*DATA_W-1:0]  result_n;
    logic                 ready_n;

    logic [DATA_W-1:0]    abs1, abs2;
    logic [DATA_W-1:0]    step_rem, step_quo;
    logic [DATA_W-1:0]    rem_fix, quo_fix;

    ex_div_step #(.DATA_W(DATA_W)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvsr_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    // The pipeline stalls while EX holds a divide whose result is not yet out
    assign stallreq = (start == DIV_START) && (ready == DIV_RESULT_NOT_READY);

    // Next-state, datapath updates and registered-output values
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        rem_n     = rem_q;
        quo_n     = quo_q;
        dvsr_n    = dvsr_q;
        neg_quo_n = neg_quo_q;
        neg_rem_n = neg_rem_q;
        result_n  = result;
        ready_n   = ready;

        // Magnitudes only for DIV; DIVU operands pass through untouched
        abs1 = (signed_div && opdata1[DATA_W-1]) ? -opdata1 : opdata1;
        abs2 = (signed_div && opdata2[DATA_W-1]) ? -opdata2 : opdata2;

        // Sign fix applied to the final iteration's output (modulo 2^DATA_W)
        rem_fix = neg_rem_q ? -step_rem : step_rem;
        quo_fix = neg_quo_q ? -step_quo : step_quo;

        case (state_q)
            DIV_FREE: begin
                ready_n = DIV_RESULT_NOT_READY;
                if (start == DIV_START) begin
                    if (opdata2 == '0) begin
                        state_n = DIV_BY_ZERO;
                    end else begin
                        rem_n     = '0;
                        quo_n     = abs1;
                        dvsr_n    = abs2;
                        neg_quo_n = signed_div & (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
                        neg_rem_n = signed_div & opdata1[DATA_W-1];
                        cnt_n     = '0;
`ifdef DIV_EARLY_OUT_EN
                        // Dividend smaller than divisor: quotient 0, remainder is the raw dividend
                        if (abs1 < abs2) begin
                            state_n  = DIV_END;
                            result_n = {opdata1, {DATA_W{1'b0}}};
                            ready_n  = DIV_RESULT_READY;
                        end else begin
                            state_n = DIV_ON;
                        end
`else
                        state_n = DIV_ON;
`endif
                    end
                end
            end
            DIV_BY_ZERO: begin
                result_n = '0;
                ready_n  = DIV_RESULT_READY;
                state_n  = DIV_END;
            end
            DIV_ON: begin
                rem_n = step_rem;
                quo_n = step_quo;
                cnt_n = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    result_n = {rem_fix, quo_fix};
                    ready_n  = DIV_RESULT_READY;
                    state_n  = DIV_END;
                end
            end
            DIV_END: begin
                ready_n = DIV_RESULT_READY;
                if (start == DIV_STOP) begin
                    ready_n = DIV_RESULT_NOT_READY;
                    state_n = DIV_FREE;
                end
            end
            default: begin
                state_n = DIV_FREE;
                ready_n = DIV_RESULT_NOT_READY;
            end
        endcase

        // A flush abandons the instruction, even one that is still asserting start
        if (flush) begin
            state_n  = DIV_FREE;
            ready_n  = DIV_RESULT_NOT_READY;
            result_n = '0;
        end
    end

    // State, iteration datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_FREE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result    <= '0;
            ready     <= DIV_RESULT_NOT_READY;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            rem_q     <= rem_n;
            quo_q     <= quo_n;
            dvsr_q    <= dvsr_n;
            neg_quo_q <= neg_quo_n;
            neg_rem_q <= neg_rem_n;
            result    <= result_n;
            ready     <= ready_n;
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: vector table plus flush, held-in-END and reset sequences.
// Latency: measures cycles from start sampled in IDLE to ready.
// Backpressure: checks stallreq duration and result hold while start stays high.
module tb_ex_div;

`ifdef DIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        start;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic [63:0] result;
    logic        ready;
    logic        stallreq;

    always #5 clk = ~clk;

    ex_div #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .start      (start),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .result     (result),
        .ready      (ready),
        .stallreq   (stallreq)
    );

    typedef struct {
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs [11];

    int checks   = 0;
    int failures = 0;
    int lat;
    int stalls;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start a divide in the current cycle and count cycles until ready (bounded)
    task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                           output int lat_o, output int stalls_o);
        signed_div = sg;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        lat_o      = 0;
        stalls_o   = 0;
        #1;
        if (stallreq) stalls_o++;
        for (int k = 0; k < 60; k++) begin
            tick();
            lat_o++;
            // Operands are latched in IDLE; scrambling them afterwards must not matter
            if (k == 0) begin
                opdata1    = $urandom;
                opdata2    = $urandom;
                signed_div = ~sg;
                #1;
            end
            if (ready) break;
            if (stallreq) stalls_o++;
        end
    endtask

    initial begin
        //        sg    dividend      divisor       quotient      remainder     latency
        vecs[0]  = '{1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        33};
        // -7/2 truncates toward zero: q=-3, r=-1
        vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 32'hFFFFFFFF, 33};
        vecs[2]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        33};
        vecs[3]  = '{1'b0, 32'd5,        32'd0,        32'd0,        32'd0,        2};
        vecs[4]  = '{1'b0, 32'd3,        32'd10,       32'd0,        32'd3,        EO_LAT};
        vecs[5]  = '{1'b0, 32'hFFFFFFFF, 32'd3,        32'h55555555, 32'd0,        33};
        vecs[6]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        33};
        vecs[7]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,        33};
        vecs[8]  = '{1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 33};
        vecs[9]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, EO_LAT};
        vecs[10] = '{1'b1, 32'hFFFFFFFD, 32'd10,       32'd0,        32'hFFFFFFFD, EO_LAT};

        rst        = 1'b1;
        flush      = 1'b0;
        start      = 1'b0;
        signed_div = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_ready", {63'd0, ready}, 64'd0);
        chk("reset_result", result, 64'd0);
        chk("reset_stallreq", {63'd0, stallreq}, 64'd0);

        for (int i = 0; i < 11; i++) begin
            run_div(vecs[i].sg, vecs[i].a, vecs[i].b, lat, stalls);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            chk($sformatf("v%0d_result", i), result, {vecs[i].r, vecs[i].q});
            chk($sformatf("v%0d_stall_cycles", i), 64'(stalls), 64'(vecs[i].lat));
            chk($sformatf("v%0d_stallreq_at_ready", i), {63'd0, stallreq}, 64'd0);
            start = 1'b0;
            tick();
            chk($sformatf("v%0d_ready_drop", i), {63'd0, ready}, 64'd0);
            chk($sformatf("v%0d_result_held", i), result, {vecs[i].r, vecs[i].q});
        end

        // Flush at t+10 of DIVU 0xFFFFFFFF/3, with start still high
        signed_div = 1'b0;
        opdata1    = 32'hFFFFFFFF;
        opdata2    = 32'd3;
        start      = 1'b1;
        #1;
        repeat (10) tick();
        chk("flush_busy_ready", {63'd0, ready}, 64'd0);
        chk("flush_busy_stallreq", {63'd0, stallreq}, 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        start = 1'b0;
        chk("flush_ready", {63'd0, ready}, 64'd0);
        chk("flush_result", result, 64'd0);
        tick();
        run_div(1'b0, 32'd9, 32'd3, lat, stalls);
        chk("post_flush_latency", 64'(lat), 64'd33);
        chk("post_flush_result", result, {32'd0, 32'd3});
        start = 1'b0;
        tick();

        // Instruction held in EX after ready: result must stay put
        run_div(1'b0, 32'd100, 32'd7, lat, stalls);
        chk("hold_latency", 64'(lat), 64'd33);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("hold%0d_ready", k), {63'd0, ready}, 64'd1);
            chk($sformatf("hold%0d_result", k), result, {32'd2, 32'd14});
            chk($sformatf("hold%0d_stallreq", k), {63'd0, stallreq}, 64'd0);
        end
        start = 1'b0;
        tick();
        chk("hold_drop_ready", {63'd0, ready}, 64'd0);
        chk("hold_drop_result", result, {32'd2, 32'd14});

        // Reset while iterating clears outputs on the next edge
        signed_div = 1'b0;
        opdata1    = 32'd9;
        opdata2    = 32'd3;
        start      = 1'b1;
        #1;
        repeat (5) tick();
        chk("rst_busy_ready", {63'd0, ready}, 64'd0);
        rst   = 1'b1;
        start = 1'b0;
        tick();
        rst = 1'b0;
        chk("rst_mid_ready", {63'd0, ready}, 64'd0);
        chk("rst_mid_result", result, 64'd0);
        tick();

        // Divider is usable again after the mid-operation reset
        run_div(1'b1, 32'hFFFFFFF9, 32'h2, lat, stalls);
        chk("post_rst_latency", 64'(lat), 64'd33);
        chk("post_rst_result", result, {32'hFFFFFFFF, 32'hFFFFFFFD});
        start = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
